// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t : FSM state encoding (IDLE, CALC, DONE)
//   DIV_N   : default divisor width; dividend and quotient are 2*DIV_N bits
package divider_pkg;

    localparam int DIV_N = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : divider_pkg

// File: rtl/div_step.sv
// One combinational restoring-division step.
// Ports:
//   part_rem [N:0]   - partial remainder from the previous step
//   next_bit         - next dividend bit (MSB first)
//   divisor  [N-1:0] - captured divisor
//   next_rem [N:0]   - partial remainder after this step
//   q_bit            - quotient bit produced by this step
module div_step
    import divider_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic [N:0]   part_rem,
    input  logic         next_bit,
    input  logic [N-1:0] divisor,
    output logic [N:0]   next_rem,
    output logic         q_bit
);

    logic [N:0]   shifted;
    logic [N+1:0] diff;
    logic         unused_msb;

    // The partial remainder is always below the divisor, so its top bit is
    // zero on entry and the shift can drop it. With a zero divisor the bits
    // shifted out are discarded, leaving the low dividend bits as remainder.
    assign shifted    = {part_rem[N-1:0], next_bit};
    assign unused_msb = part_rem[N];

    // One extra bit on the difference acts as the sign of the trial subtraction.
    assign diff     = {1'b0, shifted} - {2'b00, divisor};
    assign q_bit    = ~diff[N+1];
    assign next_rem = q_bit ? diff[N:0] : shifted;

endmodule : div_step

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: 2*N-bit dividend by N-bit divisor,
// one quotient bit per clock, MSB first.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start               - accepted in IDLE; captures dividend and divisor
//   dividend [2N-1:0]   - unsigned dividend
//   divisor  [N-1:0]    - unsigned divisor
//   quotient [2N-1:0]   - result, held until the next accepted start
//   remainder[N-1:0]    - result, held until the next accepted start
//   busy                - high in CALC and DONE
//   done                - one-cycle result-valid pulse (DONE state)
//   div_by_zero         - set with done when a zero divisor was captured
// Configuration macro: DIV_BY_ZERO_CHECK_EN -- when defined, a zero divisor
// finishes after one CALC cycle with quotient all ones and remainder zero;
// otherwise div_by_zero is tied low and the full step sequence runs.
module seq_divider
    import divider_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           busy,
    output logic           done,
    output logic           div_by_zero
);

    localparam int             STEPS = 2 * N;
    localparam int             CNT_W = $clog2(STEPS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*N-1:0]     work;    // dividend bits shift out the top, quotient bits in the bottom
    logic [N-1:0]       dvs;
    logic [N:0]         prem;
    logic [N:0]         next_rem;
    logic               q_bit;
    logic               dbz_hit;

    div_step #(.N(N)) u_step (
        .part_rem (prem),
        .next_bit (work[2*N-1]),
        .divisor  (dvs),
        .next_rem (next_rem),
        .q_bit    (q_bit)
    );

`ifdef DIV_BY_ZERO_CHECK_EN
    logic dbz_q;
    assign dbz_hit     = (dvs == '0);
    assign div_by_zero = dbz_q;
`else
    assign dbz_hit     = 1'b0;
    assign div_by_zero = 1'b0;
`endif

    // NOTE: all state lives in this one clocked block and uses non-blocking
    // assignments so every register samples pre-edge values, as hardware does.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            work      <= '0;
            dvs       <= '0;
            prem      <= '0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef DIV_BY_ZERO_CHECK_EN
            dbz_q     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CALC;
                        busy  <= 1'b1;
                        work  <= dividend;
                        dvs   <= divisor;
                        prem  <= '0;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    if (dbz_hit) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        quotient  <= '1;
                        remainder <= '0;
`ifdef DIV_BY_ZERO_CHECK_EN
                        dbz_q     <= 1'b1;
`endif
                    end else begin
                        work <= {work[2*N-2:0], q_bit};
                        prem <= next_rem;
                        cnt  <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            quotient  <= {work[2*N-2:0], q_bit};
                            remainder <= next_rem[N-1:0];
`ifdef DIV_BY_ZERO_CHECK_EN
                            dbz_q     <= 1'b0;
`endif
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (N=4): reset values, a table of known
// divisions, exhaustive non-zero operands with stray start pulses, random
// operands against an arithmetic model, abort by reset, divide by zero and
// back-to-back operation with start held high.
module tb_seq_divider;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic [2*N-1:0] quotient;
    logic [N-1:0]   remainder;
    logic           busy;
    logic           done;
    logic           div_by_zero;

    int total = 0;
    int bad   = 0;

    seq_divider #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Arithmetic reference: plain division, plus the zero-divisor rule.
    task automatic model(input int a, input int b, output int q, output int r,
                         output int dz, output int lat);
        if (b == 0) begin
            q = 255;
`ifdef DIV_BY_ZERO_CHECK_EN
            r = 0; dz = 1; lat = 2;
`else
            r = a % 16; dz = 0; lat = 2 * N + 1;
`endif
        end else begin
            q = a / b; r = a % b; dz = 0; lat = 2 * N + 1;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", {31'd0, busy}, 0);
    endtask

    // Issues one division; lat counts edges from start assertion, including
    // the sampling edge, to the cycle where done is seen.
    task automatic run_div(input logic [7:0] a, input logic [3:0] b, input bit junk,
                           output logic [7:0] q, output logic [3:0] r,
                           output logic dz, output int lat);
        bit seen = 1'b0;
        wait_idle();
        lat = 0; q = '0; r = '0; dz = 1'b0;
        dividend = a; divisor = b; start = 1'b1;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start    = 1'b0;
                dividend = 8'($urandom);
                divisor  = 4'($urandom);
            end
            if (junk && k == 3) start = 1'b1;
            if (junk && k == 4) start = 1'b0;
            if (done === 1'b1) begin
                seen = 1'b1; lat = k;
                q = quotient; r = remainder; dz = div_by_zero;
            end
        end
        start = 1'b0;
        check("done_seen", {31'd0, seen}, 1);
    endtask

    initial begin
        vec_t       vecs[7];
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
        int         lat, eq, er, edz, elat, pulses, last_k, first_k;

        vecs[0] = '{8'd200, 4'd7,  8'd28,  4'd4};
        vecs[1] = '{8'd255, 4'd1,  8'd255, 4'd0};
        vecs[2] = '{8'd3,   4'd15, 8'd0,   4'd3};
        vecs[3] = '{8'd0,   4'd5,  8'd0,   4'd0};
        vecs[4] = '{8'd255, 4'd15, 8'd17,  4'd0};
        vecs[5] = '{8'd100, 4'd9,  8'd11,  4'd1};
        vecs[6] = '{8'd128, 4'd3,  8'd42,  4'd2};

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_quotient",  {24'd0, quotient}, 0);
        check("rst_remainder", {28'd0, remainder}, 0);
        check("rst_busy",      {31'd0, busy}, 0);
        check("rst_done",      {31'd0, done}, 0);
        check("rst_dbz",       {31'd0, div_by_zero}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Known vectors
        foreach (vecs[i]) begin
            run_div(vecs[i].a, vecs[i].b, 1'b0, q, r, dz, lat);
            check($sformatf("vec%0d_q", i),   {24'd0, q}, {24'd0, vecs[i].q});
            check($sformatf("vec%0d_r", i),   {28'd0, r}, {28'd0, vecs[i].r});
            check($sformatf("vec%0d_dbz", i), {31'd0, dz}, 0);
            check($sformatf("vec%0d_lat", i), lat, 2 * N + 1);
        end

        // Reset abort at CALC step 3 of 100/9
        wait_idle();
        dividend = 8'd100; divisor = 4'd9; start = 1'b1; pulses = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 2) check("abort_busy_calc", {31'd0, busy}, 1);
            if (done === 1'b1) pulses++;
            if (k == 3) rst = 1'b1;
            if (k == 4) begin
                rst = 1'b0;
                check("abort_quotient",  {24'd0, quotient}, 0);
                check("abort_remainder", {28'd0, remainder}, 0);
                check("abort_busy",      {31'd0, busy}, 0);
                check("abort_done",      {31'd0, done}, 0);
                check("abort_dbz",       {31'd0, div_by_zero}, 0);
            end
        end
        check("abort_no_done", pulses, 0);
        run_div(8'd100, 4'd9, 1'b0, q, r, dz, lat);
        check("after_abort_q", {24'd0, q}, 11);
        check("after_abort_r", {28'd0, r}, 1);

        // Divide by zero
        run_div(8'hA5, 4'd0, 1'b0, q, r, dz, lat);
        model(8'hA5, 0, eq, er, edz, elat);
        check("dbz_q",   {24'd0, q}, eq);
        check("dbz_r",   {28'd0, r}, er);
        check("dbz_flag",{31'd0, dz}, edz);
        check("dbz_lat", lat, elat);

        // Back-to-back with start held high for 40 cycles
        wait_idle();
        dividend = 8'd200; divisor = 4'd7; start = 1'b1;
        pulses = 0; last_k = 0; first_k = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                pulses++;
                check("b2b_q", {24'd0, quotient}, 28);
                check("b2b_r", {28'd0, remainder}, 4);
                if (last_k == 0) first_k = k;
                else check("b2b_interval", k - last_k, 10);
                last_k = k;
            end
        end
        start = 1'b0;
        check("b2b_first", first_k, 2 * N + 1);
        check("b2b_pulses", pulses, 4);

        // Exhaustive non-zero operands, with a stray start pulse during CALC
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_div(8'(a), 4'(b), 1'b1, q, r, dz, lat);
                model(a, b, eq, er, edz, elat);
                check($sformatf("exh %0d/%0d", a, b), {19'd0, dz, q, r},
                      {19'd0, 1'(edz), 8'(eq), 4'(er)});
            end
        end

        // Random operands, zero divisor included
        for (int i = 0; i < 300; i++) begin
            int a, b;
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 15));
            run_div(8'(a), 4'(b), (b != 0) && $urandom_range(0, 1) == 1, q, r, dz, lat);
            model(a, b, eq, er, edz, elat);
            check($sformatf("rnd %0d/%0d", a, b), {19'd0, dz, q, r},
                  {19'd0, 1'(edz), 8'(eq), 4'(er)});
            check($sformatf("rnd_lat %0d/%0d", a, b), lat, elat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_seq_divider

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter N SHALL default to 4 and set the divisor width; the dividend and quotient are 2N bits and the remainder is N bits.
REQ-002 Port clk SHALL be an input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit; reset is synchronous and active-high.
REQ-004 Port start SHALL be an input, 1 bit, a request to begin a division.
REQ-005 Port dividend SHALL be an input, 2N bits, unsigned.
REQ-006 Port divisor SHALL be an input, N bits, unsigned.
REQ-007 Port quotient SHALL be an output, 2N bits, unsigned result.
REQ-008 Port remainder SHALL be an output, N bits, unsigned result.
REQ-009 Port busy SHALL be an output, 1 bit, high while not in IDLE.
REQ-010 Port done SHALL be an output, 1 bit, a one-cycle result-valid pulse.
REQ-011 Port div_by_zero SHALL be an output, 1 bit, valid while done is high.

Function
REQ-012 The FSM SHALL have states IDLE, CALC and DONE.
REQ-013 IDLE->CALC SHALL occur on an edge with start=1; dividend and divisor are captured on that edge.
REQ-014 start SHALL be ignored in CALC and DONE; captured operands are unaffected by later input changes.
REQ-015 CALC SHALL perform one restoring-division step per cycle, MSB first, for exactly 2N cycles:
- shift the partial remainder (N+1 bits) left, bringing in the next dividend bit;
- subtract the divisor;
- if the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0.
REQ-016 After the 2N-th step the FSM SHALL enter DONE, with quotient and remainder registered so that dividend = quotient*divisor + remainder and remainder < divisor.
REQ-017 done SHALL be high only in DONE, i.e. 2N+1 edges after the start-sampling edge; DONE->IDLE SHALL occur unconditionally next edge.
REQ-018 quotient, remainder and div_by_zero SHALL hold their values from DONE until the next start is accepted.
REQ-019 busy SHALL be high in CALC and DONE and low in IDLE.
REQ-020 A start held high continuously SHALL yield back-to-back divisions with one IDLE cycle between DONE and the next CALC.

Reset
REQ-021 rst=1 SHALL force, on the next edge: state=IDLE, quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, step counter=0.
REQ-022 rst SHALL take priority over start and SHALL abort any division in progress with no done pulse.

Configuration
REQ-023 Macro DIV_BY_ZERO_CHECK_EN, when defined, SHALL make divisor=0 captured in IDLE go CALC->DONE after one cycle. On that done pulse: div_by_zero=1, quotient = all ones, remainder=0.
REQ-024 Without DIV_BY_ZERO_CHECK_EN, div_by_zero SHALL be tied to 0. Divisor=0 then runs the full 2N steps and yields quotient = all ones and remainder = dividend[N-1:0].

Structure
REQ-025 Package divider_pkg SHALL hold the FSM state enum (IDLE, CALC, DONE) and the default width constant DIV_N=4.
REQ-026 Sub-module div_step SHALL implement one combinational restoring step. Inputs: partial remainder, incoming bit, divisor. Outputs: next partial remainder, quotient bit.

Verification
REQ-027 N=4, dividend=200, divisor=7, start one cycle -> done high exactly 9 edges later; quotient=28, remainder=4, div_by_zero=0.
REQ-028 dividend=255, divisor=1 -> quotient=255, remainder=0; dividend=3, divisor=15 -> quotient=0, remainder=3.
REQ-029 Exhaustive check of all 256x15 non-zero operand pairs against a reference model; start pulsed during CALC is ignored and the result matches the first operands.
REQ-030 rst asserted at CALC step 3 of dividend=100, divisor=9 -> no done pulse, all outputs 0 next cycle; a following start with 100/9 -> quotient=11, remainder=1.
REQ-031 divisor=0, dividend=0xA5:
- with DIV_BY_ZERO_CHECK_EN: done 2 edges after start, div_by_zero=1, quotient=0xFF, remainder=0;
- without it: done 9 edges after start, div_by_zero=0, quotient=0xFF, remainder=0x5.
REQ-032 start held high for 40 cycles with 200/7 -> done pulses every 10 cycles, each with quotient=28, remainder=4.
